// File: rtl/rx_pkt_ctrl_if.sv
// Handshake and payload bundle between the S2P receiver, rx_pkt_ctrl and the payload FIFO.
// The master modport is the side that drives the S2P/FIFO status. The slave modport is the controller.
interface rx_pkt_ctrl_if;
    logic       RX_READY_LD;
    logic       RX_LAST_BYTE;
    logic [7:0] DATA;
    logic       RX_LOAD;
    logic       fifo_full;
    logic       fifo_wr;
    logic [7:0] fifo_data;
    logic [3:0] pkt_pid;
    logic [6:0] pkt_len;
    logic       pkt_done;
    logic       pkt_err;
    logic       overrun;

    modport master (
        output RX_READY_LD, RX_LAST_BYTE, DATA, fifo_full,
        input  RX_LOAD, fifo_wr, fifo_data, pkt_pid, pkt_len, pkt_done, pkt_err, overrun
    );

    modport slave (
        input  RX_READY_LD, RX_LAST_BYTE, DATA, fifo_full,
        output RX_LOAD, fifo_wr, fifo_data, pkt_pid, pkt_len, pkt_done, pkt_err, overrun
    );
endinterface

// File: rtl/rx_pkt_ctrl.sv
// Receive packet controller: reads bytes from the S2P, takes the PID, streams the payload to a FIFO, and flags the end of each packet as good or bad.
// Optional define RX_PKT_CTRL_PID_CHECK_EN: rejects a PID byte whose upper nibble is not the complement of its lower nibble.
module rx_pkt_ctrl (
    input logic          clock,
    input logic          reset,
    rx_pkt_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_PID,
        LOAD_PID,
        WAIT_DAT,
        LOAD_DAT,
        FLUSH
    } state_t;

    state_t     state;
    state_t     next_state;

    logic       last_q;
    logic       rdy_q;
    logic       rx_load_q;
    logic       wr_pend;
    logic       pid_seen;
    logic       bad_q;
    logic       overrun_q;
    logic [7:0] data_q;
    logic [3:0] pid_q;
    logic [6:0] len_q;

    logic       last_rise;
    logic       rdy_rise;
    logic       len_full;
    logic       drop;
    logic       pid_bad;

    logic       fifo_wr_c;
    logic       pkt_done_c;
    logic       pkt_err_c;

    // A held RX_READY_LD must not trigger a second read, so only its rising edge starts a load.
    assign last_rise = bus.RX_LAST_BYTE & ~last_q;
    assign rdy_rise  = bus.RX_READY_LD & ~rdy_q;
    assign len_full  = (len_q == 7'd64);
    assign drop      = wr_pend & (bus.fifo_full | len_full);

`ifdef RX_PKT_CTRL_PID_CHECK_EN
    assign pid_bad = (bus.DATA[7:4] != ~bus.DATA[3:0]);
`else
    assign pid_bad = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            rx_load_q <= 1'b0;
        end else begin
            state     <= next_state;
            rx_load_q <= (next_state == LOAD_PID) || (next_state == LOAD_DAT);
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (!bus.RX_LAST_BYTE)
                    next_state = WAIT_PID;
            end
            WAIT_PID: begin
                if (last_rise)
                    next_state = FLUSH;
                else if (rdy_rise)
                    next_state = LOAD_PID;
            end
            WAIT_DAT: begin
                if (last_rise)
                    next_state = FLUSH;
                else if (rdy_rise)
                    next_state = LOAD_DAT;
            end
            // A load lasts one cycle, so an end-of-packet edge seen during it is acted on at its exit.
            LOAD_PID, LOAD_DAT: begin
                next_state = last_rise ? FLUSH : WAIT_DAT;
            end
            FLUSH: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_comb begin
        fifo_wr_c  = wr_pend & ~drop;
        pkt_done_c = 1'b0;
        pkt_err_c  = 1'b0;
        if (state == FLUSH) begin
            if (pid_seen && !bad_q && !drop)
                pkt_done_c = 1'b1;
            else
                pkt_err_c = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            last_q    <= 1'b1;
            rdy_q     <= 1'b0;
            wr_pend   <= 1'b0;
            pid_seen  <= 1'b0;
            bad_q     <= 1'b0;
            overrun_q <= 1'b0;
            data_q    <= 8'h00;
            pid_q     <= 4'h0;
            len_q     <= 7'd0;
        end else begin
            last_q  <= bus.RX_LAST_BYTE;
            rdy_q   <= bus.RX_READY_LD;
            wr_pend <= 1'b0;
            if (state == IDLE && next_state == WAIT_PID) begin
                pid_seen <= 1'b0;
                bad_q    <= 1'b0;
            end
            if (state == LOAD_PID) begin
                pid_q    <= bus.DATA[3:0];
                len_q    <= 7'd0;
                pid_seen <= 1'b1;
                if (pid_bad)
                    bad_q <= 1'b1;
            end
            if (state == LOAD_DAT) begin
                data_q  <= bus.DATA;
                wr_pend <= 1'b1;
            end
            // The pending byte is written the cycle after capture, or dropped if there is no room.
            if (wr_pend) begin
                if (drop)
                    bad_q <= 1'b1;
                else
                    len_q <= len_q + 7'd1;
                if (bus.fifo_full)
                    overrun_q <= 1'b1;
            end
        end
    end

    assign bus.RX_LOAD   = rx_load_q;
    assign bus.fifo_wr   = fifo_wr_c;
    assign bus.fifo_data = data_q;
    assign bus.pkt_pid   = pid_q;
    assign bus.pkt_len   = len_q;
    assign bus.pkt_done  = pkt_done_c;
    assign bus.pkt_err   = pkt_err_c;
    assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_rx_pkt_ctrl.sv
// Bench for rx_pkt_ctrl: packet table plus hand-written corner sequences.
// A FIFO-write scoreboard checks every payload byte.
module tb_rx_pkt_ctrl;

`ifdef RX_PKT_CTRL_PID_CHECK_EN
    localparam bit PID_CHK = 1'b1;
`else
    localparam bit PID_CHK = 1'b0;
`endif

    typedef struct {
        logic [7:0] pid;
        int         nbytes;
        logic [7:0] base;
        int         full_at;
        logic       exp_done;
        logic       exp_err;
        logic [6:0] exp_len;
        logic       exp_ovr;
    } vec_t;

    logic clock;
    logic reset;
    rx_pkt_ctrl_if bus();

    rx_pkt_ctrl dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int         n_compared = 0;
    int         n_failed   = 0;
    int         done_cnt   = 0;
    int         err_cnt    = 0;
    int         load_cnt   = 0;
    logic [7:0] sb_q[$];
    vec_t       vecs[6];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard and pulse counters sample away from the active edge.
    always @(negedge clock) begin
        if (!reset) begin
            if (bus.fifo_wr) begin
                if (sb_q.size() == 0) begin
                    n_compared++;
                    n_failed++;
                    $display("[TB] FAIL fifo_wr_unexpected: got data 0x%0h, expected no write", bus.fifo_data);
                end else begin
                    checkOutput("fifo_data", 32'(bus.fifo_data), 32'(sb_q.pop_front()));
                end
            end
            if (bus.pkt_done && bus.pkt_err) begin
                n_compared++;
                n_failed++;
                $display("[TB] FAIL done_err_both: got both high, expected at most one");
            end
            if (bus.pkt_done) done_cnt++;
            if (bus.pkt_err)  err_cnt++;
            if (bus.RX_LOAD)  load_cnt++;
        end
    end

    task automatic stepCycle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic sendByte(input logic [7:0] b);
        logic got;
        got = 1'b0;
        bus.DATA        = b;
        bus.RX_READY_LD = 1'b1;
        for (int k = 0; k < 8 && !got; k++) begin
            @(negedge clock);
            if (bus.RX_LOAD) got = 1'b1;
        end
        if (!got) begin
            n_compared++;
            n_failed++;
            $display("[TB] FAIL rx_load_timeout: got no RX_LOAD, expected one within 8 cycles");
        end
        @(posedge clock);
        #1;
        bus.RX_READY_LD = 1'b0;
        stepCycle(1);
    endtask

    task automatic applyStimulus(input vec_t v);
        int         d0;
        int         e0;
        int         l0;
        logic [7:0] b;
        d0 = done_cnt;
        e0 = err_cnt;
        l0 = load_cnt;
        bus.RX_LAST_BYTE = 1'b0;
        stepCycle(2);
        sendByte(v.pid);
        for (int i = 0; i < v.nbytes; i++) begin
            b = v.base + 8'(i) * 8'h11;
            bus.fifo_full = (i == v.full_at);
            if (!bus.fifo_full && i < 64)
                sb_q.push_back(b);
            sendByte(b);
            bus.fifo_full = 1'b0;
        end
        bus.RX_LAST_BYTE = 1'b1;
        stepCycle(4);
        checkOutput("pkt_done_pulses", 32'(done_cnt - d0), 32'(v.exp_done));
        checkOutput("pkt_err_pulses", 32'(err_cnt - e0), 32'(v.exp_err));
        checkOutput("rx_load_pulses", 32'(load_cnt - l0), 32'(v.nbytes + 1));
        checkOutput("pkt_len", 32'(bus.pkt_len), 32'(v.exp_len));
        checkOutput("pkt_pid", 32'(bus.pkt_pid), 32'(v.pid[3:0]));
        checkOutput("overrun", 32'(bus.overrun), 32'(v.exp_ovr));
        checkOutput("writes_outstanding", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        int d0;
        int e0;
        int l0;

        vecs[0] = '{pid: 8'hC3, nbytes: 3,  base: 8'h11, full_at: -1, exp_done: 1'b1,     exp_err: 1'b0,    exp_len: 7'd3,  exp_ovr: 1'b0};
        vecs[1] = '{pid: 8'h00, nbytes: 1,  base: 8'h5E, full_at: -1, exp_done: !PID_CHK, exp_err: PID_CHK, exp_len: 7'd1,  exp_ovr: 1'b0};
        vecs[2] = '{pid: 8'h5A, nbytes: 0,  base: 8'h00, full_at: -1, exp_done: 1'b1,     exp_err: 1'b0,    exp_len: 7'd0,  exp_ovr: 1'b0};
        vecs[3] = '{pid: 8'h96, nbytes: 64, base: 8'h01, full_at: -1, exp_done: 1'b1,     exp_err: 1'b0,    exp_len: 7'd64, exp_ovr: 1'b0};
        vecs[4] = '{pid: 8'hE1, nbytes: 65, base: 8'h07, full_at: -1, exp_done: 1'b0,     exp_err: 1'b1,    exp_len: 7'd64, exp_ovr: 1'b0};
        vecs[5] = '{pid: 8'h4B, nbytes: 2,  base: 8'hAA, full_at: 1,  exp_done: 1'b0,     exp_err: 1'b1,    exp_len: 7'd1,  exp_ovr: 1'b1};

        reset            = 1'b1;
        bus.RX_READY_LD  = 1'b0;
        bus.RX_LAST_BYTE = 1'b1;
        bus.DATA         = 8'h00;
        bus.fifo_full    = 1'b0;
        stepCycle(3);
        checkOutput("rst_rx_load", 32'(bus.RX_LOAD), 32'd0);
        checkOutput("rst_fifo_wr", 32'(bus.fifo_wr), 32'd0);
        checkOutput("rst_fifo_data", 32'(bus.fifo_data), 32'd0);
        checkOutput("rst_pkt_pid", 32'(bus.pkt_pid), 32'd0);
        checkOutput("rst_pkt_len", 32'(bus.pkt_len), 32'd0);
        checkOutput("rst_done_err", 32'({bus.pkt_done, bus.pkt_err}), 32'd0);
        checkOutput("rst_overrun", 32'(bus.overrun), 32'd0);
        reset = 1'b0;
        stepCycle(2);

        // A stale byte flag while idle must not produce a read.
        l0 = load_cnt;
        bus.DATA        = 8'hEE;
        bus.RX_READY_LD = 1'b1;
        stepCycle(3);
        bus.RX_READY_LD = 1'b0;
        stepCycle(2);
        checkOutput("idle_ready_ignored", 32'(load_cnt - l0), 32'd0);

        // End of packet with no bytes at all: missing PID.
        d0 = done_cnt;
        e0 = err_cnt;
        bus.RX_LAST_BYTE = 1'b0;
        stepCycle(2);
        bus.RX_LAST_BYTE = 1'b1;
        stepCycle(4);
        checkOutput("empty_pkt_err", 32'(err_cnt - e0), 32'd1);
        checkOutput("empty_pkt_done", 32'(done_cnt - d0), 32'd0);

        // RX_READY_LD held four cycles for a single PID byte.
        d0 = done_cnt;
        l0 = load_cnt;
        bus.RX_LAST_BYTE = 1'b0;
        stepCycle(2);
        bus.DATA        = 8'hC3;
        bus.RX_READY_LD = 1'b1;
        stepCycle(4);
        bus.RX_READY_LD = 1'b0;
        stepCycle(2);
        checkOutput("held_ready_loads", 32'(load_cnt - l0), 32'd1);
        bus.RX_LAST_BYTE = 1'b1;
        stepCycle(4);
        checkOutput("held_ready_pid", 32'(bus.pkt_pid), 32'h3);
        checkOutput("held_ready_len", 32'(bus.pkt_len), 32'd0);
        checkOutput("held_ready_done", 32'(done_cnt - d0), 32'd1);

        for (int i = 0; i < 6; i++)
            applyStimulus(vecs[i]);

        // Reset in the middle of a packet aborts it silently and clears the sticky overrun.
        d0 = done_cnt;
        e0 = err_cnt;
        bus.RX_LAST_BYTE = 1'b0;
        stepCycle(2);
        sendByte(8'hD2);
        sb_q.push_back(8'h31);
        sendByte(8'h31);
        sb_q.push_back(8'h42);
        sendByte(8'h42);
        checkOutput("pre_reset_len", 32'(bus.pkt_len), 32'd2);
        reset            = 1'b1;
        bus.RX_LAST_BYTE = 1'b1;
        stepCycle(1);
        checkOutput("midrst_pid", 32'(bus.pkt_pid), 32'd0);
        checkOutput("midrst_len", 32'(bus.pkt_len), 32'd0);
        checkOutput("midrst_overrun", 32'(bus.overrun), 32'd0);
        checkOutput("midrst_fifo_data", 32'(bus.fifo_data), 32'd0);
        reset = 1'b0;
        stepCycle(4);
        checkOutput("midrst_no_pulse", 32'((done_cnt - d0) + (err_cnt - e0)), 32'd0);
        applyStimulus(vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule

// File: doc/rx_pkt_ctrl.md
RX_PKT_CTRL -- requirements
Module: rx_pkt_ctrl

Interface
REQ-001 SHALL have port clock, input, 1: sole clock; all logic updates on its rising edge.
REQ-002 SHALL have port reset, input, 1: synchronous, active-high reset, sampled on rising clock.
REQ-003 SHALL have port RX_READY_LD, input, 1: S2P byte-available flag.
REQ-004 SHALL have port RX_LAST_BYTE, input, 1: S2P end-of-packet indication (high while receive inactive).
REQ-005 SHALL have port DATA, input, 8: S2P read data, valid only while RX_LOAD high.
REQ-006 SHALL have port RX_LOAD, output, 1: registered read strobe to S2P.
REQ-007 SHALL have port fifo_full, input, 1: downstream payload FIFO full.
REQ-008 SHALL have port fifo_wr, output, 1: one-cycle payload write strobe.
REQ-009 SHALL have port fifo_data, output, 8: payload byte, valid with fifo_wr.
REQ-010 SHALL have port pkt_pid, output, 4: PID[3:0] of the current/last packet.
REQ-011 SHALL have port pkt_len, output, 7: payload byte count of the current/last packet.
REQ-012 SHALL have port pkt_done, output, 1: one-cycle end-of-good-packet pulse.
REQ-013 SHALL have port pkt_err, output, 1: one-cycle end-of-bad-packet pulse.
REQ-014 SHALL have port overrun, output, 1: sticky; set when a byte is dropped on fifo_full; cleared only by reset.

Function
REQ-015 SHALL implement states IDLE, WAIT_PID, LOAD_PID, WAIT_DAT, LOAD_DAT, FLUSH.
REQ-016 IDLE SHALL go to WAIT_PID when RX_LAST_BYTE is low.
REQ-017 WAIT_PID/WAIT_DAT with RX_READY_LD high SHALL go to LOAD_PID/LOAD_DAT; RX_LOAD SHALL be high exactly during LOAD_* (one cycle).
REQ-018 DATA SHALL be captured at the rising edge that ends a LOAD_* cycle; LOAD_* SHALL then return to WAIT_DAT, so each RX_READY_LD assertion yields exactly one read.
REQ-019 First captured byte SHALL be the PID: pkt_pid <= DATA[3:0]; pkt_len SHALL be cleared to 0 at the same edge.
REQ-020 Each later captured byte SHALL drive fifo_wr high the next cycle with fifo_data = byte, and increment pkt_len, unless fifo_full is high at that cycle.
REQ-021 If fifo_full is high when the write would issue: no fifo_wr, byte dropped, overrun set, packet marked bad.
REQ-022 Rising edge of RX_LAST_BYTE (previous sample low, current high) in WAIT_PID/WAIT_DAT SHALL go to FLUSH; in LOAD_* it SHALL be latched and acted on when that state exits.
REQ-023 FLUSH SHALL, for one cycle, pulse pkt_done if the packet is good, else pkt_err, then go to IDLE.
REQ-024 A packet SHALL be bad if: no PID byte received, pkt_len would exceed 64 (the 65th byte is dropped and pkt_len saturates at 64), any drop per REQ-021, or the PID check in REQ-030 fails.
REQ-025 pkt_done and pkt_err SHALL never be high together; a PID-only packet (pkt_len 0) with a passing PID is good.
REQ-026 pkt_pid and pkt_len SHALL hold their values from FLUSH until the next PID capture.
REQ-027 RX_READY_LD high while in IDLE or FLUSH SHALL be ignored (stale byte, no RX_LOAD).

Reset
REQ-028 While reset is high at a rising clock: state IDLE; RX_LOAD, fifo_wr, pkt_done, pkt_err, overrun = 0; fifo_data, pkt_pid, pkt_len = 0; edge-detect register = 1.
REQ-029 Reset mid-packet SHALL abort with no pkt_done/pkt_err pulse; the next packet starts from IDLE.

Configuration
REQ-030 With RX_PKT_CTRL_PID_CHECK_EN defined, the PID byte SHALL be bad unless DATA[7:4] == ~DATA[3:0]; without it, any PID byte is accepted and only the REQ-024 length/overrun/missing-PID rules apply.

Verification
REQ-031 Packet bytes 0xC3,0x11,0x22,0x33, then RX_LAST_BYTE rises -> 3 fifo_wr (0x11,0x22,0x33), pkt_pid=0x3, pkt_len=3, one pkt_done pulse.
REQ-032 RX_READY_LD held high 4 cycles for one byte -> exactly one RX_LOAD pulse and one capture.
REQ-033 fifo_full high during 2nd payload byte of 0x4B,0xAA,0xBB -> one fifo_wr (0xAA), overrun=1 (sticky), pkt_err pulse.
REQ-034 PID 0x00 + 1 payload byte -> pkt_err with RX_PKT_CTRL_PID_CHECK_EN defined; pkt_done without it.
REQ-035 PID plus 65 payload bytes -> 64 fifo_wr, pkt_len=64, pkt_err; RX_LAST_BYTE rising with no bytes -> pkt_err.
REQ-036 reset asserted after 2 payload bytes -> all outputs reset next edge, no pulse; next clean packet ends with pkt_done.
